// File: rtl/exclusive_min_n.sv
// N-input exclusive-min with gamma-cycle framing: the first unique rising edge per gamma cycle wins.
// Optional macro EXCLUSIVE_MIN_TIE_BREAK_EN: simultaneous first arrivals fire the lowest index instead of blocking.
module exclusive_min_n #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic                                 gamma_start,
  input  logic [N_INPUTS-1:0]                  in_spikes,
  output logic                                 q,
  output logic                                 win_valid,
  output logic [$clog2(N_INPUTS)-1:0]          win_idx,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] t_win,
  output logic                                 tie
);

  localparam int IDX_W  = $clog2(N_INPUTS);
  localparam int SLOT_W = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int PC_W   = $clog2(PULSE_WIDTH + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] FIRE    = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] BLOCKED = 3'd4;

  logic [2:0]          state, state_n, cur;
  logic [SLOT_W-1:0]   cnt, slot;
  logic [N_INPUTS-1:0] prev, rise;
  logic [PC_W-1:0]     pcnt, pcnt_n;
  logic                last_slot, multi;
  logic [IDX_W-1:0]    low_idx, idx_n;
  logic [SLOT_W-1:0]   tw_n;
  logic                q_n, wv_n, tie_n;

  assign slot      = gamma_start ? '0 : cnt;
  assign last_slot = (slot == SLOT_W'(GAMMA_CYCLE_WIDTH - 1));
  assign rise      = in_spikes & ~prev;
  assign multi     = (rise & (rise - N_INPUTS'(1))) != '0;

  always_comb begin
    low_idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (rise[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    cur    = state;
    q_n    = q;
    wv_n   = win_valid;
    tie_n  = tie;
    idx_n  = win_idx;
    tw_n   = t_win;
    pcnt_n = pcnt;
    // A new gamma cycle clears the old result and evaluates this cycle as slot 0 of ARMED.
    if (gamma_start) begin
      cur   = ARMED;
      q_n   = 1'b0;
      wv_n  = 1'b0;
      tie_n = 1'b0;
    end
    state_n = cur;
    if (cur != IDLE && last_slot) begin
      state_n = ARMED;
      q_n     = 1'b0;
      wv_n    = 1'b0;
      tie_n   = 1'b0;
    end else begin
      case (cur)
        ARMED: begin
          if (rise != '0) begin
`ifdef EXCLUSIVE_MIN_TIE_BREAK_EN
            state_n = FIRE;
            q_n     = 1'b1;
            wv_n    = 1'b1;
            tie_n   = multi;
            idx_n   = low_idx;
            tw_n    = slot;
            pcnt_n  = PC_W'(PULSE_WIDTH - 1);
`else
            if (multi) begin
              state_n = BLOCKED;
              tie_n   = 1'b1;
            end else begin
              state_n = FIRE;
              q_n     = 1'b1;
              wv_n    = 1'b1;
              idx_n   = low_idx;
              tw_n    = slot;
              pcnt_n  = PC_W'(PULSE_WIDTH - 1);
            end
`endif
          end
        end
        FIRE: begin
          if (pcnt == '0) begin
            q_n     = 1'b0;
            state_n = HOLD;
          end else begin
            pcnt_n = pcnt - PC_W'(1);
          end
        end
        default: state_n = cur;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state     <= IDLE;
      cnt       <= '0;
      prev      <= '0;
      pcnt      <= '0;
      q         <= 1'b0;
      win_valid <= 1'b0;
      tie       <= 1'b0;
      win_idx   <= '0;
      t_win     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= last_slot ? '0 : slot + SLOT_W'(1);
      prev      <= in_spikes;
      pcnt      <= pcnt_n;
      q         <= q_n;
      win_valid <= wv_n;
      tie       <= tie_n;
      win_idx   <= idx_n;
      t_win     <= tw_n;
    end
  end

endmodule

// File: tb/tb_exclusive_min_n.sv
// Randomized bench for exclusive_min_n against a per-gamma-cycle reference model, with literal spot checks.
module tb_exclusive_min_n;
  localparam int N = 4;
  localparam int G = 16;
  localparam int P = 8;

  logic       aclk = 1'b0;
  logic       grst = 1'b1;
  logic       gamma_start = 1'b0;
  logic [3:0] in_spikes = '0;
  logic       q, win_valid, tie;
  logic [1:0] win_idx;
  logic [3:0] t_win;

  exclusive_min_n #(.N_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .in_spikes(in_spikes),
    .q(q), .win_valid(win_valid), .win_idx(win_idx), .t_win(t_win), .tie(tie)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state
  bit         m_active = 0, m_dec = 0, m_fire = 0;
  int         m_cnt = 0, m_fs = 0;
  logic [3:0] m_prev = '0;
  logic       e_q = 0, e_wv = 0, e_tie = 0;
  logic [1:0] e_idx = '0;
  logic [3:0] e_tw = '0;
  logic [3:0] cur = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int s, ns, pc;
    logic [3:0] r;
    bit boundary;
    if (grst) begin
      m_active = 0; m_dec = 0; m_fire = 0; m_cnt = 0; m_prev = '0;
      e_q = 0; e_wv = 0; e_tie = 0; e_idx = '0; e_tw = '0;
      return;
    end
    s = gamma_start ? 0 : m_cnt;
    r = in_spikes & ~m_prev;
    if (gamma_start) begin
      m_active = 1; m_dec = 0; m_fire = 0; e_wv = 0; e_tie = 0;
    end
    boundary = m_active && (s == G - 1);
    if (boundary) begin
      m_dec = 0; m_fire = 0; e_wv = 0; e_tie = 0;
    end else if (m_active && !m_dec && r != 0) begin
      m_dec = 1;
      m_fs  = s;
      pc    = $countones(r);
      e_tie = (pc > 1);
`ifdef EXCLUSIVE_MIN_TIE_BREAK_EN
      m_fire = 1;
`else
      m_fire = (pc == 1);
`endif
      e_wv = m_fire;
      if (m_fire) begin
        for (int i = 3; i >= 0; i--) if (r[i]) e_idx = 2'(i);
        e_tw = 4'(s);
      end
    end
    ns  = s + 1;
    e_q = m_fire && !boundary && (ns > m_fs) && (ns <= m_fs + P);
    m_cnt  = (s == G - 1) ? 0 : s + 1;
    m_prev = in_spikes;
  endtask

  task automatic step(input bit gs, input logic [3:0] v, input bit rst = 1'b0);
    grst = rst;
    gamma_start = gs;
    in_spikes = v;
    cur = v;
    @(posedge aclk);
    model_update();
    #1;
  endtask

  always @(negedge aclk) begin
    if (chk_on) begin
      chk("q", q, e_q);
      chk("win_valid", win_valid, e_wv);
      chk("tie", tie, e_tie);
      if (e_wv) begin
        chk("win_idx", win_idx, e_idx);
        chk("t_win", t_win, e_tw);
      end
    end
  end

  initial begin
    chk_on = 1'b1;
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    chk("rst_q", q, 0); chk("rst_wv", win_valid, 0); chk("rst_tie", tie, 0);
    chk("rst_idx", win_idx, 0); chk("rst_tw", t_win, 0);
    step(0, 4'b0001);
    chk("idle_ignore", win_valid, 0);

    // 1: in[2] rises in slot 5
    step(1, 4'b0000);
    for (int s = 1; s <= 4; s++) step(0, 4'b0000);
    step(0, 4'b0100);
    chk("t1_q6", q, 1); chk("t1_idx", win_idx, 2); chk("t1_tw", t_win, 5); chk("t1_wv", win_valid, 1);
    for (int s = 6; s <= 12; s++) step(0, 4'b0100);
    chk("t1_q13", q, 1);
    step(0, 4'b0100);
    chk("t1_q14", q, 0); chk("t1_wv14", win_valid, 1);
    step(0, 4'b0100);
    step(0, 4'b0100);
    chk("t1_wv0", win_valid, 0); chk("t1_q0", q, 0);
    for (int s = 0; s <= 4; s++) step(0, 4'b0100);
    chk("t1_held_high", win_valid, 0);

    // 2: in[1] and in[3] together in slot 3
    step(1, 4'b0000);
    for (int s = 1; s <= 2; s++) step(0, 4'b0000);
    step(0, 4'b1010);
    chk("t2_tie", tie, 1);
`ifdef EXCLUSIVE_MIN_TIE_BREAK_EN
    chk("t2_q", q, 1); chk("t2_idx", win_idx, 1); chk("t2_wv", win_valid, 1);
`else
    chk("t2_q", q, 0); chk("t2_wv", win_valid, 0);
    step(0, 4'b1010); step(0, 4'b1011);
    chk("t2_blocked", q, 0);
`endif

    // 3: in[0] slot 4, in[1] slot 6
    step(1, 4'b0000);
    for (int s = 1; s <= 3; s++) step(0, 4'b0000);
    step(0, 4'b0001); step(0, 4'b0001); step(0, 4'b0011);
    chk("t3_idx", win_idx, 0); chk("t3_tw", t_win, 4);
    for (int s = 7; s <= 11; s++) step(0, 4'b0011);
    chk("t3_q12", q, 1);
    step(0, 4'b0011);
    chk("t3_q13", q, 0);

    // 4: in[3] slot 12 truncated; edge in guard slot ignored
    step(1, 4'b0000);
    for (int s = 1; s <= 11; s++) step(0, 4'b0000);
    step(0, 4'b1000);
    chk("t4_q13", q, 1);
    step(0, 4'b1000); step(0, 4'b1000);
    chk("t4_q15", q, 1);
    step(0, 4'b1000);
    chk("t4_q0", q, 0);
    step(1, 4'b0000);
    for (int s = 1; s <= 14; s++) step(0, 4'b0000);
    step(0, 4'b0001);
    chk("t4_guard", win_valid, 0);
    step(0, 4'b0000); step(0, 4'b0010);
    chk("t4_rearmed", win_idx, 1);

    // 5: grst in slot 9 of a pulse
    step(1, 4'b0000);
    step(0, 4'b0100);
    for (int s = 2; s <= 8; s++) step(0, 4'b0100);
    step(0, 4'b0100, 1);
    chk("t5_q", q, 0); chk("t5_wv", win_valid, 0); chk("t5_tw", t_win, 0);
    step(0, 4'b0000); step(0, 4'b0010);
    chk("t5_idle", win_valid, 0);

    // 6: gamma_start with in[3] rise
    step(0, 4'b0000);
    step(1, 4'b1000);
    chk("t6_tw", t_win, 0); chk("t6_idx", win_idx, 3); chk("t6_q", q, 1);
    for (int s = 1; s <= 7; s++) step(0, 4'b1000);
    chk("t6_q8", q, 1);
    step(0, 4'b1000);
    chk("t6_end", q, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] nv;
      int b;
      bit gs, rs;
      nv = cur;
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(0, 3);
        nv[b] = ~nv[b];
      end
      if ($urandom_range(0, 30) == 0) nv = cur ^ 4'($urandom_range(1, 15));
      gs = ($urandom_range(0, 35) == 0);
      rs = ($urandom_range(0, 400) == 0);
      step(gs, nv, rs);
    end
    step(0, cur);
    @(negedge aclk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
